// File: rtl/snake_body_engine.sv
`timescale 1ns/1ps
// snake_body_engine: grid snake movement and body engine.
// Body segments live in a circular buffer indexed from the head pointer hp
// (segment age k sits at hp-k). Each accepted step computes the next head,
// serially scans the live body for self-collision, then commits the move.
// Build option: define SNAKE_WRAP_EN to make the field wrap at its edges
// instead of ending the game at the walls.
module snake_body_engine #(
    parameter int CELL     = 10,
    parameter int GRID_W   = 80,
    parameter int GRID_H   = 60,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 4,
    parameter int START_Y  = 4
) (
    input  logic        uclk,
    input  logic        rst,
    input  logic        step,
    input  logic [2:0]  dir,
    input  logic [6:0]  fruit_x,
    input  logic [6:0]  fruit_y,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    output logic [6:0]  head_x,
    output logic [6:0]  head_y,
    output logic [6:0]  length,
    output logic        busy,
    output logic        eat,
    output logic        game_over,
    output logic        on_head,
    output logic        on_body
);

    localparam int PW = $clog2(MAX_LEN);

    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_RIGHT = 3'd4;

    localparam logic signed [7:0] GW_S     = 8'(GRID_W);
    localparam logic signed [7:0] GH_S     = 8'(GRID_H);
    localparam logic [6:0]        GW_M1    = 7'(GRID_W - 1);
    localparam logic [6:0]        GH_M1    = 7'(GRID_H - 1);
    localparam logic [6:0]        LEN_MAX  = 7'(MAX_LEN);
    localparam logic [6:0]        LEN_INIT = 7'(INIT_LEN);
    localparam logic [PW-1:0]     HP_INIT  = PW'(INIT_LEN - 1);
    localparam logic [11:0]       CELL_W   = 12'(CELL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NEXT,
        S_SCAN,
        S_COMMIT
    } state_t;

    state_t        state;
    logic [6:0]    seg_x [MAX_LEN];
    logic [6:0]    seg_y [MAX_LEN];
    logic [PW-1:0] hp;
    logic [PW-1:0] hp_inc;
    logic [PW-1:0] scan_ptr;
    logic [2:0]    heading;
    logic [6:0]    nxt_x;
    logic [6:0]    nxt_y;
    logic          wall;
    logic          self_hit;
    logic          fruit_hit;
    logic [6:0]    idx;
    logic [6:0]    last_idx;

    logic signed [7:0] cand_x;
    logic signed [7:0] cand_y;
    logic              off_x;
    logic              off_y;
    logic [6:0]        wrap_x;
    logic [6:0]        wrap_y;
    logic              out_of_field;
    logic              dir_ok;
    logic              fruit_next;
    logic              room;
    logic [6:0]        n_cmp;
    logic              head_hit;
    logic              body_hit;

    // Slots beyond the initial body are never live, so their contents are don't-care.
    function automatic logic [6:0] init_x(input int i);
        if (i < INIT_LEN) return 7'(START_X - INIT_LEN + 1 + i);
        return 7'd0;
    endfunction

    function automatic logic [6:0] init_y(input int i);
        if (i < INIT_LEN) return 7'(START_Y);
        return 7'd0;
    endfunction

    assign head_x   = seg_x[hp];
    assign head_y   = seg_y[hp];
    assign hp_inc   = hp + PW'(1);
    assign scan_ptr = hp - idx[PW-1:0];

    // A requested direction is taken unless it would reverse the snake onto itself.
    always_comb begin
        case (dir)
            D_UP:    dir_ok = (heading != D_DOWN);
            D_DOWN:  dir_ok = (heading != D_UP);
            D_LEFT:  dir_ok = (heading != D_RIGHT);
            D_RIGHT: dir_ok = (heading != D_LEFT);
            default: dir_ok = 1'b0;
        endcase
    end

    // Candidate next head from the latched heading, with edge handling.
    always_comb begin
        cand_x = $signed({1'b0, head_x});
        cand_y = $signed({1'b0, head_y});
        case (heading)
            D_UP:    cand_y = cand_y - 8'sd1;
            D_DOWN:  cand_y = cand_y + 8'sd1;
            D_LEFT:  cand_x = cand_x - 8'sd1;
            default: cand_x = cand_x + 8'sd1;
        endcase
        off_x  = (cand_x < 8'sd0) || (cand_x >= GW_S);
        off_y  = (cand_y < 8'sd0) || (cand_y >= GH_S);
        wrap_x = cand_x[6:0];
        wrap_y = cand_y[6:0];
`ifdef SNAKE_WRAP_EN
        if (off_x) wrap_x = (cand_x < 8'sd0) ? GW_M1 : 7'd0;
        if (off_y) wrap_y = (cand_y < 8'sd0) ? GH_M1 : 7'd0;
        out_of_field = 1'b0;
`else
        out_of_field = off_x || off_y;
`endif
    end

    // Fruit hit and scan length: the tail only stays put when the snake actually grows.
    always_comb begin
        fruit_next = (wrap_x == fruit_x) && (wrap_y == fruit_y);
        room       = (length < LEN_MAX);
        if (fruit_next && room) begin
            n_cmp = length - 7'd1;
        end else if (length >= 7'd2) begin
            n_cmp = length - 7'd2;
        end else begin
            n_cmp = 7'd0;
        end
    end

    // Pixel hit test against every live segment; age 0 is the head.
    always_comb begin
        head_hit = 1'b0;
        body_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            logic [PW-1:0] age;
            logic [11:0]   x0;
            logic [11:0]   y0;
            logic          in_cell;
            age     = hp - PW'(i);
            x0      = 12'(seg_x[i]) * CELL_W;
            y0      = 12'(seg_y[i]) * CELL_W;
            in_cell = ({1'b0, pix_x} >= x0) && ({1'b0, pix_x} < x0 + CELL_W) &&
                      ({1'b0, pix_y} >= y0) && ({1'b0, pix_y} < y0 + CELL_W);
            if (in_cell && (7'(age) < length)) begin
                if (age == '0) head_hit = 1'b1;
                else           body_hit = 1'b1;
            end
        end
    end

    // Register the pixel flags so the colour mux sees a clean one-clock delay.
    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            on_head <= 1'b0;
            on_body <= 1'b0;
        end else begin
            on_head <= head_hit;
            on_body <= body_hit;
        end
    end

    // Move sequencer: IDLE -> NEXT -> (SCAN) -> COMMIT, owning the body buffer.
    always_ff @(posedge uclk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            hp        <= HP_INIT;
            length    <= LEN_INIT;
            heading   <= D_RIGHT;
            busy      <= 1'b0;
            eat       <= 1'b0;
            game_over <= 1'b0;
            nxt_x     <= 7'd0;
            nxt_y     <= 7'd0;
            wall      <= 1'b0;
            self_hit  <= 1'b0;
            fruit_hit <= 1'b0;
            idx       <= 7'd0;
            last_idx  <= 7'd0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
        end else begin
            eat       <= 1'b0;
            game_over <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step) begin
                        if (dir_ok) heading <= dir;
                        busy  <= 1'b1;
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    nxt_x     <= wrap_x;
                    nxt_y     <= wrap_y;
                    wall      <= out_of_field;
                    fruit_hit <= fruit_next;
                    self_hit  <= 1'b0;
                    idx       <= 7'd1;
                    last_idx  <= n_cmp;
                    if (out_of_field || (n_cmp == 7'd0)) state <= S_COMMIT;
                    else                                 state <= S_SCAN;
                end
                S_SCAN: begin
                    if ((seg_x[scan_ptr] == nxt_x) && (seg_y[scan_ptr] == nxt_y)) self_hit <= 1'b1;
                    if (idx == last_idx) state <= S_COMMIT;
                    else                 idx   <= idx + 7'd1;
                end
                S_COMMIT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (wall || self_hit) begin
                        hp        <= HP_INIT;
                        length    <= LEN_INIT;
                        heading   <= D_RIGHT;
                        game_over <= 1'b1;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            seg_x[i] <= init_x(i);
                            seg_y[i] <= init_y(i);
                        end
                    end else begin
                        hp            <= hp_inc;
                        seg_x[hp_inc] <= nxt_x;
                        seg_y[hp_inc] <= nxt_y;
                        if (fruit_hit && room) length <= length + 7'd1;
                        eat <= fruit_hit;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/snake_body_engine.md
# snake_body_engine

Grid-based snake movement and body engine for the VGA snake game, superseding the fixed 26-slot pixel stack. Stores up to MAX_LEN body segments in a circular buffer, applies one move per `step` pulse with reverse-direction filtering, serially scans for self-collision, handles fruit growth and wall/game-over, and provides registered per-pixel head/body hit flags to the colour mux.

## Interface
- CELL, 10: cell size in pixels.
- GRID_W, 80: field width in cells (800 px).
- GRID_H, 60: field height in cells (600 px).
- MAX_LEN, 32: body capacity; power of two, 4..64.
- INIT_LEN, 3: length after reset/game over; 1..MAX_LEN, ≤ START_X+1.
- START_X, 4 / START_Y, 4: initial head cell.

- uclk  in  1  system clock.
- rst  in  1  asynchronous reset, active high.
- step  in  1  one-cycle move request (from `mover` edge logic).
- dir  in  3  1 up, 2 down, 3 left, 4 right; 0/5..7 keep heading.
- fruit_x / fruit_y  in  7  fruit cell coordinates.
- pix_x / pix_y  in  11  current VGA pixel.
- head_x / head_y  out  7  committed head cell.
- length  out  7  current segment count incl. head.
- busy  out  1  move in progress; `step` ignored while high.
- eat  out  1  one-cycle pulse: head landed on fruit.
- game_over  out  1  one-cycle pulse: wall or self hit; snake reinitialised.
- on_head / on_body  out  1  registered: pixel inside head / other live segment.

Clock is `uclk`; reset `rst` is asynchronous and active-high.

## Operation
- Storage: seg_x/seg_y[MAX_LEN], head pointer hp. Segment age k sits at (hp−k) mod MAX_LEN; entry is live iff age < length.
- Heading register, reset = right. dir opposite to heading ignored; otherwise latched at step acceptance.
- FSM IDLE → NEXT → SCAN → COMMIT → IDLE.
- IDLE: step=1 → latch heading, go NEXT. busy=0 only here.
- NEXT: compute next head with 8-bit signed arithmetic; hit_fruit = (next == fruit). Out of field → COMMIT with wall flag set, no scan. Else SCAN, idx=1.
- SCAN: one comparison per cycle, next vs segment age idx. Compares ages 1..length−1 if hit_fruit and length<MAX_LEN (tail stays), else 1..length−2 (tail vacates); head (age 0) compared by the 180° rule is impossible, skipped. Any match sets self flag; scan still completes. Zero compares → straight to COMMIT.
- COMMIT: wall or self → game over: hp=INIT_LEN−1, segments age k at (START_X−k, START_Y), length=INIT_LEN, heading right, game_over pulse. Else hp+1 mod MAX_LEN, write next at hp, length+1 if hit_fruit and length<MAX_LEN; eat pulses on any fruit hit (incl. at full length, no growth).
- Pixel path: per live segment, hit iff seg·CELL ≤ pix < seg·CELL+CELL on both axes; on_head for age 0, on_body for ages ≥1; registered.

## Timing
- Reset: head=(START_X,START_Y), length=INIT_LEN, busy/eat/game_over/on_head/on_body=0, state IDLE, heading right. rst mid-move aborts immediately; no pulses.
- step sampled at edge E0; busy high from E0 until return to IDLE. NEXT at E1; N compares occupy E2..E1+N; COMMIT edge E2+N updates head/length and asserts eat/game_over for exactly that following cycle; IDLE at E2+N.
- Latency step→head update: N+2 edges; N ≤ MAX_LEN−1.
- step while busy: dropped, not queued.
- Pixel flags: 1 uclk latency from pix_x/pix_y; reflect state committed before the sampling edge.
- hp and age arithmetic wrap mod MAX_LEN.

## Configuration
- SNAKE_WRAP_EN defined: crossing an edge wraps to opposite edge (x=−1→GRID_W−1, x=GRID_W→0, same for y); no wall game over.
- Undefined: any out-of-field next head → game over.

## Test plan
- Reset, read state -> head (4,4), length 3, on_body at pixel (35,45) (cell 3,4), on_head at (45,45).
- dir=4, step ×1 -> busy 3 cycles (N=1), head (5,4), length 3, tail cell (2,4) no longer on_body.
- Fruit at (5,4), dir=4, step -> eat pulse 1 cycle, length 4, N=2 latency 4.
- Heading right, dir=3, step -> reverse ignored, head moves right.
- Head at (0,4), dir=3 after up/left turn, step -> without SNAKE_WRAP_EN game_over pulse, head (4,4), length 3; with it head (79,4).
- Grow to length 5, move up, left, down into own body -> game_over after full scan; step during busy has no effect.
